// File: rtl/tag_sysid_checker.sv
// Avalon-MM read master that probes the sysid slave (ID word, then timestamp word)
// and reports sticky pass / mismatch / timeout status with the captured values.
module tag_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h606F_FD69,
    parameter int unsigned TIMEOUT_CYCLES     = 255,
    parameter int unsigned TIMEOUT_W          = 8,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_mismatch,
    output logic        ts_mismatch,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_ID,
        S_WAIT_ID,
        S_REQ_TS,
        S_WAIT_TS,
        S_FINISH
    } state_t;

    // Counter holds (cycles spent in the transaction - 1); this value marks the last allowed cycle.
    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 auto_q, auto_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;
    logic                 idm_q, idm_d;
    logic                 tsm_q, tsm_d;
    logic                 to_q, to_d;
    logic [31:0]          idv_q, idv_d;
    logic [31:0]          tsv_q, tsv_d;

    logic                 expired;
    logic                 accept;

    assign avm_read    = (state_q == S_REQ_ID) || (state_q == S_REQ_TS);
    assign avm_address = (state_q == S_REQ_TS);
    assign accept      = avm_read && !avm_waitrequest;
    assign expired     = (cnt_q >= TO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        auto_d  = auto_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        pass_d  = pass_q;
        idm_d   = idm_q;
        tsm_d   = tsm_q;
        to_d    = to_q;
        idv_d   = idv_q;
        tsv_d   = tsv_q;

        case (state_q)
            S_IDLE: begin
                if (start || auto_q) begin
                    auto_d  = 1'b0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    idm_d   = 1'b0;
                    tsm_d   = 1'b0;
                    to_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = S_REQ_ID;
                end
            end

            S_REQ_ID: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                if (accept && avm_readdatavalid) begin
                    idv_d   = avm_readdata;
                    idm_d   = (avm_readdata != EXPECTED_ID);
                    cnt_d   = '0;
                    state_d = S_REQ_TS;
                end else if (expired) begin
                    to_d    = 1'b1;
                    state_d = S_FINISH;
                end else if (accept) begin
                    state_d = S_WAIT_ID;
                end
            end

            S_WAIT_ID: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                if (avm_readdatavalid) begin
                    idv_d   = avm_readdata;
                    idm_d   = (avm_readdata != EXPECTED_ID);
                    cnt_d   = '0;
                    state_d = S_REQ_TS;
                end else if (expired) begin
                    to_d    = 1'b1;
                    state_d = S_FINISH;
                end
            end

            S_REQ_TS: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                if (accept && avm_readdatavalid) begin
                    tsv_d   = avm_readdata;
                    tsm_d   = (avm_readdata != EXPECTED_TIMESTAMP);
                    state_d = S_FINISH;
                end else if (expired) begin
                    to_d    = 1'b1;
                    state_d = S_FINISH;
                end else if (accept) begin
                    state_d = S_WAIT_TS;
                end
            end

            S_WAIT_TS: begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
                if (avm_readdatavalid) begin
                    tsv_d   = avm_readdata;
                    tsm_d   = (avm_readdata != EXPECTED_TIMESTAMP);
                    state_d = S_FINISH;
                end else if (expired) begin
                    to_d    = 1'b1;
                    state_d = S_FINISH;
                end
            end

            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = !idm_q && !tsm_q && !to_q;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            auto_q  <= AUTO_START;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            idm_q   <= 1'b0;
            tsm_q   <= 1'b0;
            to_q    <= 1'b0;
            idv_q   <= '0;
            tsv_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            auto_q  <= auto_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            idm_q   <= idm_d;
            tsm_q   <= tsm_d;
            to_q    <= to_d;
            idv_q   <= idv_d;
            tsv_q   <= tsv_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign id_mismatch = idm_q;
    assign ts_mismatch = tsm_q;
    assign timeout     = to_q;
    assign id_value    = idv_q;
    assign ts_value    = tsv_q;

endmodule

// File: tb/tb_tag_sysid_checker.sv
// Scoreboard bench for tag_sysid_checker: a configurable sysid slave, a per-probe
// outcome model computed from transaction costs, and a decoupled done monitor.
module tb_tag_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h606F_FD69;
    localparam int          TO     = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        busy, done, pass, id_mismatch, ts_mismatch, timeout;
    logic [31:0] id_value, ts_value;

    always #5 clock = ~clock;

    tag_sysid_checker #(
        .EXPECTED_ID       (EXP_ID),
        .EXPECTED_TIMESTAMP(EXP_TS),
        .TIMEOUT_CYCLES    (TO),
        .TIMEOUT_W         (8),
        .AUTO_START        (1'b1)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .id_mismatch      (id_mismatch),
        .ts_mismatch      (ts_mismatch),
        .timeout          (timeout),
        .id_value         (id_value),
        .ts_value         (ts_value)
    );

    typedef struct {
        logic        pass, idm, tsm, to, ts_read;
        logic [31:0] idv, tsv;
        int          done_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;

    // slave behaviour per address: waitrequest cycles, read latency, data, no response
    int          cfg_wait[2];
    int          cfg_lat[2];
    logic [31:0] cfg_data[2];
    bit          cfg_nr[2];

    logic [31:0] prev_idv, prev_tsv;
    int          req_cyc, pend;
    logic [31:0] pend_data;
    bit          seen_ts_req;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    function automatic int txn_cost(input int w, input int l, input bit nr);
        if (nr) return TO + 1;
        return w + 1 + l;
    endfunction

    // Outcome of a probe whose start is sampled on the edge after cycle n.
    task automatic expect_probe(input int n);
        exp_t e;
        int   t1, t2;
        e.idv = prev_idv; e.tsv = prev_tsv;
        e.idm = 1'b0; e.tsm = 1'b0; e.to = 1'b0; e.ts_read = 1'b0;
        t2 = 0;
        t1 = txn_cost(cfg_wait[0], cfg_lat[0], cfg_nr[0]);
        if (t1 > TO) begin
            e.to = 1'b1;
            t1   = TO;
        end else begin
            e.idv     = cfg_data[0];
            e.idm     = (cfg_data[0] != EXP_ID);
            e.ts_read = 1'b1;
            t2 = txn_cost(cfg_wait[1], cfg_lat[1], cfg_nr[1]);
            if (t2 > TO) begin
                e.to = 1'b1;
                t2   = TO;
            end else begin
                e.tsv = cfg_data[1];
                e.tsm = (cfg_data[1] != EXP_TS);
            end
        end
        e.pass     = !e.idm && !e.tsm && !e.to;
        e.done_cyc = n + 2 + t1 + t2;
        prev_idv   = e.idv;
        prev_tsv   = e.tsv;
        sb.push_back(e);
    endtask

    task automatic set_cfg(input int w0, input int l0, input logic [31:0] d0, input bit nr0,
                           input int w1, input int l1, input logic [31:0] d1, input bit nr1);
        cfg_wait[0] = w0; cfg_lat[0] = l0; cfg_data[0] = d0; cfg_nr[0] = nr0;
        cfg_wait[1] = w1; cfg_lat[1] = l1; cfg_data[1] = d1; cfg_nr[1] = nr1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && sb.size() != 0; i++) begin
            @(posedge clock); #2;
        end
        check("probe_completes", sb.size(), 0);
        sb.delete();
        repeat (8) @(posedge clock);
        #2;
    endtask

    task automatic run_probe();
        expect_probe(cyc);
        pulse_start();
        wait_idle();
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_flags"}, {busy, done, pass, id_mismatch, ts_mismatch, timeout,
                               avm_read, avm_address}, 8'h00);
        check({nm, "_values"}, {id_value, ts_value}, 64'h0);
    endtask

    // Sysid slave model, updated just after each edge.
    initial begin
        avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
        req_cyc = 0; pend = 0; pend_data = '0;
        forever begin
            @(posedge clock); #1;
            avm_readdatavalid = 1'b0;
            if (reset) begin
                pend = 0; req_cyc = 0; avm_waitrequest = 1'b0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = pend_data;
                    end
                end
                if (avm_read) begin
                    if (req_cyc < cfg_wait[avm_address]) begin
                        avm_waitrequest = 1'b1;
                        req_cyc++;
                    end else begin
                        avm_waitrequest = 1'b0;
                        req_cyc = 0;
                        if (!cfg_nr[avm_address]) begin
                            if (cfg_lat[avm_address] == 0) begin
                                avm_readdatavalid = 1'b1;
                                avm_readdata      = cfg_data[avm_address];
                            end else begin
                                pend      = cfg_lat[avm_address];
                                pend_data = cfg_data[avm_address];
                            end
                        end
                    end
                end else begin
                    req_cyc = 0;
                    avm_waitrequest = 1'($urandom_range(0, 1));
                    // stray readdatavalid while idle must be ignored
                    if (!busy && pend == 0 && !avm_readdatavalid && $urandom_range(0, 3) == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = $urandom;
                    end
                end
            end
        end
    end

    // Monitor: request stability, read only while busy, and done-time scoreboard compare.
    initial begin
        bit   seen1, prev_rw;
        logic prev_addr;
        exp_t e;
        seen1 = 0; prev_rw = 0; prev_addr = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                seen1 = 0; prev_rw = 0;
                continue;
            end
            if (avm_read && avm_address) seen1 = 1;
            if (prev_rw) check("req_stable", {avm_read, avm_address}, {1'b1, prev_addr});
            if (avm_read) check("read_while_busy", busy, 1'b1);
            prev_rw   = avm_read && avm_waitrequest;
            prev_addr = avm_address;
            if (done) begin
                check("done_expected", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("done_cycle", cyc, e.done_cyc);
                    check("pass", pass, e.pass);
                    check("id_mismatch", id_mismatch, e.idm);
                    check("ts_mismatch", ts_mismatch, e.tsm);
                    check("timeout", timeout, e.to);
                    check("id_value", id_value, e.idv);
                    check("ts_value", ts_value, e.tsv);
                    check("busy_at_done", busy, 1'b0);
                    check("ts_read_issued", seen1, e.ts_read);
                end
                seen1 = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; seen_ts_req = 0;
        prev_idv = '0; prev_tsv = '0;
        set_cfg(0, 1, EXP_ID, 0, 0, 1, EXP_TS, 0);
        repeat (3) @(posedge clock);
        #2;
        check_zero("reset_state");

        // auto probe after release: nominal slave
        reset = 1'b0;
        expect_probe(cyc);
        wait_idle();

        // timestamp off by one
        set_cfg(0, 1, EXP_ID, 0, 0, 1, 32'h606F_FD6A, 0);
        run_probe();

        // long waitrequest on both requests
        set_cfg(10, 1, EXP_ID, 0, 10, 1, EXP_TS, 0);
        run_probe();

        // ID never answers, then TS never answers
        set_cfg(0, 1, EXP_ID, 1, 0, 1, EXP_TS, 0);
        run_probe();
        set_cfg(0, 1, 32'h1234_5678, 0, 0, 1, EXP_TS, 1);
        run_probe();

        // zero-latency slave
        set_cfg(0, 0, EXP_ID, 0, 0, 0, EXP_TS, 0);
        run_probe();

        // transaction exactly at the limit, then one cycle over
        set_cfg(10, 5, EXP_ID, 0, 0, 1, EXP_TS, 0);
        run_probe();
        set_cfg(10, 6, EXP_ID, 0, 0, 1, EXP_TS, 0);
        run_probe();

        // start while busy is ignored
        set_cfg(3, 2, EXP_ID, 0, 3, 2, EXP_TS, 0);
        expect_probe(cyc);
        pulse_start();
        repeat (3) @(posedge clock);
        #2;
        pulse_start();
        wait_idle();

        // start during FINISH is ignored
        set_cfg(0, 1, EXP_ID, 0, 0, 1, EXP_TS, 0);
        expect_probe(cyc);
        pulse_start();
        repeat (4) @(posedge clock);
        #2;
        pulse_start();
        wait_idle();

        // reset while waiting for the timestamp word
        set_cfg(0, 1, EXP_ID, 0, 0, 4, EXP_TS, 0);
        expect_probe(cyc);
        pulse_start();
        seen_ts_req = 0;
        for (int i = 0; i < 50; i++) begin
            if (avm_read && avm_address) seen_ts_req = 1;
            if (seen_ts_req && !avm_read) break;
            @(posedge clock); #2;
        end
        check("reached_wait_ts", seen_ts_req && !avm_read && busy, 1'b1);
        reset = 1'b1;
        #1;
        check_zero("reset_in_wait_ts");
        sb.delete();
        prev_idv = '0; prev_tsv = '0;
        set_cfg(0, 1, EXP_ID, 0, 0, 1, EXP_TS, 0);
        repeat (2) @(posedge clock);
        #2;
        reset = 1'b0;
        expect_probe(cyc);
        wait_idle();

        // randomized slave behaviour and data
        for (int k = 0; k < 25; k++) begin
            for (int a = 0; a < 2; a++) begin
                logic [31:0] good;
                int          r;
                good        = (a == 0) ? EXP_ID : EXP_TS;
                cfg_wait[a] = int'($urandom_range(0, 6));
                cfg_lat[a]  = int'($urandom_range(0, 5));
                cfg_nr[a]   = ($urandom_range(0, 9) == 0);
                r = int'($urandom_range(0, 3));
                if (r == 0)      cfg_data[a] = $urandom;
                else if (r == 1) cfg_data[a] = good ^ (32'h1 << $urandom_range(0, 31));
                else             cfg_data[a] = good;
            end
            run_probe();
        end

        repeat (10) @(posedge clock);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
